fetch_queue: RTL

Parametrised instruction-fetch front end for the next-generation core. It replaces the bare PC register and combinational instruction-memory read of the single-cycle CPU. The block owns the program counter, issues pipelined requests to a variable-latency, in-order instruction memory, and buffers returned instructions in a DEPTH-entry queue. It presents {instr, pc, pc+STEP} to decode with a valid/ready handshake, and supports branch redirect with flush plus a sticky halt.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the instruction-fetch front end.
// Default geometry matches the 16-bit core; widths are derived from DEPTH.
package fetch_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_PC_STEP = 2;

    // Counters must hold the value DEPTH itself, pointers only 0..DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);
    localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of DEPTH entries (DEPTH a power of two) with push, pop and
// flush; flush wins over both. Pointers wrap naturally at DEPTH.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; a slot is only read once written, and rdata is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= wdata;
    end

    assign rdata = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, keeps up to DEPTH requests in
// flight to an in-order memory and queues returned instructions for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pcs,
    input  logic              if_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              hlt_in,
    output logic              halted
);

    localparam int                CNT_W = cnt_width(DEPTH);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W:0]    in_flight;
    logic              halt;
    logic              issue;
    logic              resp_keep;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head_entry;

    // Slots already committed (queued or in flight) bound new requests, so a response always has room.
    assign in_flight  = {1'b0, occupancy} + {1'b0, outstanding};
    assign issue      = ~rst & ~halt & ~redirect & (in_flight < (CNT_W + 1)'(DEPTH));
    assign resp_keep  = imem_valid & (drop == '0) & ~redirect & ~fifo_full;
    assign pop        = if_valid & if_ready & ~redirect;
    assign push_entry = '{instr: imem_rdata, pc: resp_pc};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .pop   (pop),
        .flush (redirect),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // NOTE: non-blocking assignments let every register here sample the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            halt        <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_valid);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop     <= outstanding - CNT_W'(imem_valid);
            end else begin
                if (issue)     fetch_pc <= fetch_pc + STEP;
                if (resp_keep) resp_pc  <= resp_pc + STEP;
                if (imem_valid && drop != '0) drop <= drop - 1'b1;
            end
            if (hlt_in)        halt <= 1'b1;
            else if (redirect) halt <= 1'b0;
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        if_pcs   = '0;
        if (!fifo_empty) begin
            if_valid = 1'b1;
            if_instr = head_entry.instr;
            if_pc    = head_entry.pc;
            if_pcs   = head_entry.pc + STEP;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign halted    = halt;

endmodule
